// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops plus iterative unsigned
// multiply (shift-add) and divide (restoring) behind a valid/ready handshake.
module seq_alu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       AluOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             Zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_SLT  = 4'b1010;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_NOR  = 4'b0111;
   localparam logic [3:0] OP_MULL = 4'b1000;
   localparam logic [3:0] OP_MULH = 4'b1001;
   localparam logic [3:0] OP_DIVU = 4'b1100;
   localparam logic [3:0] OP_REMU = 4'b1101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic [CNT_W-1:0] cnt_q;
   logic             is_div_q;
   logic             sel_hi_q;
   logic [WIDTH-1:0] opd_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic [WIDTH-1:0] diff_c;
   logic             ovf_c;
   logic             slt_c;
   logic [WIDTH-1:0] sc_res_c;
   logic             is_iter_c;

   logic [WIDTH:0]   mul_sum_c;
   logic [WIDTH:0]   rem_sh_c;
   logic [WIDTH-1:0] trial_c;
   logic             ge_c;
   logic [WIDTH-1:0] hi_d;
   logic [WIDTH-1:0] lo_d;
   logic [WIDTH-1:0] fin_d;

   // Single-cycle ops; slt uses sign of A-B corrected by signed overflow
   always_comb begin
      diff_c    = A - B;
      ovf_c     = (A[WIDTH-1] ^ B[WIDTH-1]) & (diff_c[WIDTH-1] ^ A[WIDTH-1]);
      slt_c     = diff_c[WIDTH-1] ^ ovf_c;
      is_iter_c = AluOp inside {OP_MULL, OP_MULH, OP_DIVU, OP_REMU};
      sc_res_c  = '0;
      case (AluOp)
         OP_ADD:  sc_res_c = A + B;
         OP_SUB:  sc_res_c = diff_c;
         OP_SLT:  sc_res_c = WIDTH'(slt_c);
         OP_AND:  sc_res_c = A & B;
         OP_OR:   sc_res_c = A | B;
         OP_XOR:  sc_res_c = A ^ B;
         OP_NOR:  sc_res_c = ~(A | B);
         default: sc_res_c = '0;
      endcase
   end

   // One iteration: {hi,lo} is the product accumulator or the {remainder,quotient} pair
   always_comb begin
      mul_sum_c = {1'b0, hi_q} + {1'b0, opd_q};
      rem_sh_c  = {hi_q, lo_q[WIDTH-1]};
      ge_c      = rem_sh_c >= {1'b0, opd_q};
      trial_c   = rem_sh_c[WIDTH-1:0] - opd_q;
      if (is_div_q) begin
         hi_d = ge_c ? trial_c : rem_sh_c[WIDTH-1:0];
         lo_d = {lo_q[WIDTH-2:0], ge_c};
      end else if (lo_q[0]) begin
         hi_d = mul_sum_c[WIDTH:1];
         lo_d = {mul_sum_c[0], lo_q[WIDTH-1:1]};
      end else begin
         hi_d = {1'b0, hi_q[WIDTH-1:1]};
         lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
      end
      fin_d = sel_hi_q ? hi_d : lo_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         cnt_q       <= '0;
         is_div_q    <= 1'b0;
         sel_hi_q    <= 1'b0;
         opd_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  in_ready_q <= 1'b0;
                  if (is_iter_c) begin
                     is_div_q <= AluOp[2];
                     sel_hi_q <= AluOp[0];
                     opd_q    <= AluOp[2] ? B : A;
                     lo_q     <= AluOp[2] ? A : B;
                     hi_q     <= '0;
                     cnt_q    <= CNT_W'(WIDTH);
                     state_q  <= S_BUSY;
                  end else begin
                     result_q    <= sc_res_c;
                     zero_q      <= (sc_res_c == '0);
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end
               end
            end
            S_BUSY: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  result_q    <= fin_d;
                  zero_q      <= (fin_d == '0);
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign Result    = result_q;
   assign Zero      = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: a WIDTH=32 and a WIDTH=8 instance checked every cycle
// against a transaction-level reference model, plus directed literal cases.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iv   [2];
   logic        ir   [2];
   logic [3:0]  op   [2];
   logic [31:0] a    [2];
   logic [31:0] b    [2];
   logic        ov   [2];
   logic        ordy [2];
   logic        z    [2];
   logic [31:0] res32;
   logic [7:0]  res8;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference model state: 0 idle, 1 computing, 2 result presented
   int          phase [2];
   int          wcnt  [2];
   logic [31:0] mres  [2];

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .AluOp(op[0]),
      .A(a[0]), .B(b[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .Result(res32), .Zero(z[0]));

   seq_alu #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .AluOp(op[1]),
      .A(a[1][7:0]), .B(b[1][7:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .Result(res8), .Zero(z[1]));

   function automatic int wid(input int i);
      return (i == 0) ? 32 : 8;
   endfunction

   function automatic logic [31:0] get_res(input int i);
      return (i == 0) ? res32 : {24'd0, res8};
   endfunction

   function automatic bit is_iter(input logic [3:0] o);
      return (o == 4'd8) || (o == 4'd9) || (o == 4'd12) || (o == 4'd13);
   endfunction

   function automatic logic [31:0] ref_op(input logic [3:0] o, input logic [31:0] a_in,
                                          input logic [31:0] b_in, input int w);
      longint unsigned mask, x, y, r;
      longint sx, sy;
      mask = (64'd1 << w) - 64'd1;
      x = a_in & mask;
      y = b_in & mask;
      sx = ((x >> (w - 1)) != 0) ? longint'(x) - longint'(64'd1 << w) : longint'(x);
      sy = ((y >> (w - 1)) != 0) ? longint'(y) - longint'(64'd1 << w) : longint'(y);
      case (o)
         4'd0:    r = x + y;
         4'd2:    r = x - y;
         4'd10:   r = (sx < sy) ? 64'd1 : 64'd0;
         4'd4:    r = x & y;
         4'd5:    r = x | y;
         4'd6:    r = x ^ y;
         4'd7:    r = ~(x | y);
         4'd8:    r = x * y;
         4'd9:    r = (x * y) >> w;
         4'd12:   r = (y == 0) ? mask : x / y;
         4'd13:   r = (y == 0) ? x : x % y;
         default: r = 64'd0;
      endcase
      return 32'(r & mask);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            phase[i] <= 0;
            wcnt[i]  <= 0;
            mres[i]  <= '0;
         end else begin
            case (phase[i])
               0: if (iv[i]) begin
                     mres[i] <= ref_op(op[i], a[i], b[i], wid(i));
                     if (is_iter(op[i])) begin
                        phase[i] <= 1;
                        wcnt[i]  <= wid(i);
                     end else begin
                        phase[i] <= 2;
                     end
                  end
               1: if (wcnt[i] == 1) phase[i] <= 2;
                  else wcnt[i] <= wcnt[i] - 1;
               default: if (ordy[i]) phase[i] <= 0;
            endcase
         end
      end
   end

   // Every-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk(i == 0 ? "w32_in_ready" : "w8_in_ready", 32'(ir[i]), 32'(phase[i] == 0));
            chk(i == 0 ? "w32_out_valid" : "w8_out_valid", 32'(ov[i]), 32'(phase[i] == 2));
            if (phase[i] == 2) begin
               chk(i == 0 ? "w32_result" : "w8_result", get_res(i), mres[i]);
               chk(i == 0 ? "w32_zero" : "w8_zero", 32'(z[i]), 32'(mres[i] == 0));
            end
         end
      end
   end

   task automatic do_op(input int i, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int exp_lat, input int hold, input string nm);
      int lat;
      chk({nm, "_ready_before"}, 32'(ir[i]), 32'd1);
      iv[i] = 1'b1; op[i] = o; a[i] = x; b[i] = y;
      @(posedge clk); #2;
      iv[i] = 1'b0; op[i] = 4'($urandom); a[i] = $urandom; b[i] = $urandom;
      lat = 1;
      while (!ov[i] && lat < 100) begin
         @(posedge clk); #2;
         lat++;
      end
      chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({nm, "_result"}, get_res(i), exp);
      chk({nm, "_zero"}, 32'(z[i]), 32'(exp == 0));
      for (int k = 0; k < hold; k++) begin
         iv[i] = 1'($urandom); op[i] = 4'($urandom); a[i] = $urandom; b[i] = $urandom;
         @(posedge clk); #2;
         chk({nm, "_hold_result"}, get_res(i), exp);
         chk({nm, "_hold_in_ready"}, 32'(ir[i]), 32'd0);
      end
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
      @(posedge clk); #2;
      ordy[i] = 1'b0;
      chk({nm, "_release_valid"}, 32'(ov[i]), 32'd0);
      chk({nm, "_release_ready"}, 32'(ir[i]), 32'd1);
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0; op[i] = '0; a[i] = '0; b[i] = '0; ordy[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      chk_en = 1'b1;
      chk("reset_result", res32, 32'd0);
      chk("reset_zero", 32'(z[0]), 32'd1);
      chk("reset_in_ready", 32'(ir[0]), 32'd1);
      chk("reset_out_valid", 32'(ov[0]), 32'd0);

      chk("model_mulh32", ref_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32), 32'hFFFF_FFFE);
      chk("model_slt32", ref_op(4'd10, 32'h7FFF_FFFF, 32'h8000_0000, 32), 32'd0);
      chk("model_div0", ref_op(4'd12, 32'd5, 32'd0, 32), 32'hFFFF_FFFF);
      chk("model_mulh8", ref_op(4'd9, 32'hFF, 32'hFF, 8), 32'hFE);

      do_op(0, 4'b0000, 32'hFFFF_FFFF, 32'd1,           32'd0,         1,  0, "add_wrap");
      do_op(0, 4'b0010, 32'd5,         32'd7,           32'hFFFF_FFFE, 1,  0, "sub");
      do_op(0, 4'b1010, 32'h8000_0000, 32'd1,           32'd1,         1,  0, "slt_neg");
      do_op(0, 4'b1010, 32'h7FFF_FFFF, 32'h8000_0000,   32'd0,         1,  0, "slt_ovf");
      do_op(0, 4'b0111, 32'd0,         32'd0,           32'hFFFF_FFFF, 1,  0, "nor");
      do_op(0, 4'b1111, 32'h1234,      32'h5678,        32'd0,         1,  0, "op_1111");
      do_op(0, 4'b1000, 32'd7,         32'd6,           32'h2A,        33, 0, "mull");
      do_op(0, 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,   32'hFFFF_FFFE, 33, 0, "mulh");
      do_op(0, 4'b1100, 32'd100,       32'd7,           32'd14,        33, 0, "divu");
      do_op(0, 4'b1101, 32'd100,       32'd7,           32'd2,         33, 0, "remu");
      do_op(0, 4'b1100, 32'd5,         32'd0,           32'hFFFF_FFFF, 33, 0, "divu_zero");
      do_op(0, 4'b1101, 32'd5,         32'd0,           32'd5,         33, 0, "remu_zero");
      do_op(0, 4'b1000, 32'd1234,      32'd5678,        32'd7006652,   33, 10, "backpressure");
      do_op(1, 4'b1001, 32'hFF,        32'hFF,          32'hFE,        9,  0, "w8_mulh");
      do_op(1, 4'b1100, 32'd200,       32'd3,           32'd66,        9,  0, "w8_divu");

      // Reset in the middle of a multiply
      iv[0] = 1'b1; op[0] = 4'b1000; a[0] = 32'd9; b[0] = 32'd9;
      @(posedge clk); #2;
      iv[0] = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(ov[0]), 32'd0);
      chk("abort_result", res32, 32'd0);
      chk("abort_zero", 32'(z[0]), 32'd1);
      chk("abort_in_ready", 32'(ir[0]), 32'd1);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #2;
         if (ov[0]) seen = 1'b1;
      end
      chk("abort_no_stale", 32'(seen), 32'd0);

      // Randomized traffic on both instances, including back-to-back requests
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clk); #2;
         for (int i = 0; i < 2; i++) begin
            logic [31:0] ra, rb;
            iv[i]   = ($urandom % 4) != 0;
            op[i]   = 4'($urandom);
            ra      = ($urandom % 3 == 0) ? ($urandom % 16) : $urandom;
            rb      = ($urandom % 8 == 0) ? 32'd0 : (($urandom % 3 == 0) ? ($urandom % 16) : $urandom);
            a[i]    = (i == 0) ? ra : (ra & 32'hFF);
            b[i]    = (i == 0) ? rb : (rb & 32'hFF);
            ordy[i] = ($urandom % 3) != 0;
         end
      end
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0; ordy[i] = 1'b0;
      end
      @(posedge clk); #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU, the next generation of the single-cycle datapath ALU. It keeps the existing 4-bit operation encoding for add, sub, slt and the logic ops, generalised to `WIDTH` bits, with overflow-correct signed compare. It adds iterative unsigned multiply (low/high) and divide (quotient/remainder). It sits in the execute stage behind a valid/ready handshake so the controller can stall on long operations.

## Interface
- `WIDTH`, 32: operand/result width in bits, ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request.
- `AluOp`  in  4  operation code, see Operation.
- `A`, `B`  in  WIDTH each  operands.
- `out_valid`  out  1  `Result`/`Zero` valid.
- `out_ready`  in  1  consumer takes result.
- `Result`  out  WIDTH  registered result.
- `Zero`  out  1  `Result == 0`.

## Operation
- Opcodes: 0000 add; 0010 sub (A−B); 1010 slt (signed A<B → 1, else 0); 0100 and; 0101 or; 0110 xor; 0111 nor.
- 1000 mul low (low WIDTH bits of unsigned A·B); 1001 mul high (high WIDTH bits of unsigned A·B).
- 1100 divu quotient; 1101 remu remainder.
- Any other code is a single-cycle op with Result = 0, Zero = 1.
- Add/sub wrap modulo 2^WIDTH. No carry or overflow output.
- slt is overflow-correct: compare the sign of A−B XOR signed overflow. It does not use the raw sign bit.
- Multiply is shift-add, one bit per cycle over WIDTH cycles, into a 2·WIDTH accumulator.
- Divide is restoring, one quotient bit per cycle over WIDTH cycles.
- Divide by zero: quotient = all ones, remainder = A. It still takes the full WIDTH iterations.
- Operands and opcode are captured on accept. Input changes after accept have no effect.
- FSM states:
  - IDLE: `in_ready` = 1. On accept, a single-cycle op computes and goes to DONE. A mul/div op loads the operand registers and counter = WIDTH, then goes to BUSY.
  - BUSY: one iteration per cycle, counter decrements. When counter reaches 1, the final iteration writes `Result` and the state goes to DONE.
  - DONE: `out_valid` = 1 and `Result` is held stable. When `out_ready` = 1, go to IDLE.
- `in_ready` = 1 only in IDLE. There is no accept in the same cycle as a DONE handshake; throughput is at most one op per 2 cycles.
- `Zero` is derived from the registered `Result` and is meaningful only while `out_valid` = 1.

## Timing
- Reset (async, `rst_n` = 0) sets state to IDLE, `in_ready` = 1 after reset, `out_valid` = 0, `Result` = 0, `Zero` = 1, counter = 0 and accumulators = 0.
- Reset asserted mid-BUSY or in DONE aborts the operation immediately. No result is ever presented for it.
- Accept happens at edge T with `in_valid` & `in_ready`.
- Single-cycle ops: `out_valid` = 1 from T+1.
- mul/div ops: BUSY for cycles T+1..T+WIDTH, `out_valid` = 1 from T+WIDTH+1. Latency is exactly WIDTH+1 cycles, independent of operand values.
- `out_valid` stays high until the first edge with `out_ready` = 1. `Result` does not change while `out_valid` = 1.
- `out_ready` is ignored when `out_valid` = 0. `in_valid` is ignored when `in_ready` = 0; a request is not queued.

## Test plan
- Reset: hold `rst_n` = 0 mid-multiply, release → `out_valid` = 0, `Result` = 0, `Zero` = 1, `in_ready` = 1, and no stale result appears afterwards.
- Single-cycle ops (WIDTH=32):
  - add 0xFFFFFFFF+1 → 0, Zero = 1, at T+1.
  - sub 5−7 → 0xFFFFFFFE.
  - slt 0x80000000 vs 1 → 1.
  - slt 0x7FFFFFFF vs 0x80000000 → 0.
  - nor 0,0 → 0xFFFFFFFF.
  - opcode 1111 → 0.
- Multiply:
  - mul low 7·6 → 0x0000002A.
  - mul high 0xFFFFFFFF·0xFFFFFFFF → 0xFFFFFFFE.
  - Both with `out_valid` first seen exactly 33 cycles after accept.
- Divide:
  - divu 100/7 → 14; remu → 2.
  - divu 5/0 → 0xFFFFFFFF; remu 5/0 → 5.
  - Latency 33 cycles.
- Backpressure: hold `out_ready` = 0 for 10 cycles after `out_valid` while toggling A/B/AluOp/`in_valid` → `Result` stays stable and `in_ready` = 0. Then `out_ready` = 1 → IDLE next cycle.
- WIDTH=8 instance:
  - mul high 0xFF·0xFF → 0xFE.
  - divu 200/3 → 66 with latency 9.
  - Random ops against a reference model, including back-to-back requests.
